hit_sram_4b_wrapper: RTL and testbench
======================================

Name: hit_sram_4b_wrapper

Overview:
- Circular one-bit hit buffer for the ETROC2 readout L1 path.
- Every clock cycle, the current pixel hit flag is written at the write address.
- On an L1 accept (rden), the flag stored at the delayed read address is returned on outHit.
- Storage is 512 one-bit entries, packed as 128 words of 4 bits (the "4B" organization).

Parameters:
- ADDR_WIDTH, 9, address width; depth is 2**ADDR_WIDTH = 512 entries.
- WORD_BITS, 4, bits per internal memory word.
- Internal word count is 512/4 = 128, addressed by addr[8:2].

Ports:
- clk  input  1  rising-edge clock, 40 MHz (25 ns period).
- reset  input  1  asynchronous, active-low reset.
- hit  input  1  hit flag to store this cycle.
- wrAddr  input  9  write address; written unconditionally every cycle.
- rden  input  1  read enable (L1A).
- rdAddr  input  9  read address, normally wrAddr minus the L1 latency (modulo 512).
- outHit  output  1  registered read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - outHit goes to 0 immediately.
  - All 512 stored bits clear to 0.
  - Writes and reads are ignored while reset is low.
- Write, every rising edge with reset=1:
  - Location mem[wrAddr] <= hit.
  - Word index is wrAddr[8:2], bit lane is wrAddr[1:0].
  - Only that one bit changes; the other 3 bits of the word are preserved (per-bit write enable, no read-modify-write).
- Read, on a rising edge with rden=1:
  - outHit <= mem[rdAddr].
  - Latency is 1 cycle: data is valid the cycle after rden is sampled.
- Read with rden=0: outHit holds its previous value.
- Same-cycle read and write to the same address: read-before-write; outHit returns the old content. Exception: see the optional feature.
- Same word, different lane (rdAddr[8:2]==wrAddr[8:2], lanes differ): the read returns the stored bit unaffected by the write.
- Address arithmetic: all addresses are 9-bit modulo 512.
  - Wrap from 511 to 0 needs no special handling.
  - Any entry is overwritten exactly 512 cycles after its write when wrAddr increments by 1 per cycle.
- No overflow or underflow flags; the block is a pure circular store.
- Reset deasserted mid-operation: the first rising edge after release performs a normal write and an optional read.

Optional Feature:
- Macro: HIT_SRAM_WRITE_FIRST_EN.
- Defined: when rden=1 and rdAddr==wrAddr in the same cycle, outHit <= hit (write-first bypass).
- Undefined (default): read-before-write as specified above.
- No other behaviour differs.

Decomposition:
- Shared package: ADDR_WIDTH=9, WORD_BITS=4, WORDS=128, and a lane-select helper (addr[1:0] to a 4-bit one-hot write mask).
- One sub-module, hit_sram_bank:
  - 128x4 storage with async active-low clear.
  - 7-bit write word address, 4-bit bit-write mask, 4-bit write data.
  - 7-bit read word address, 4-bit combinational read word.
- The wrapper does lane decode, lane mux of the read word, the optional bypass, and the outHit register.

Test Plan:
- Reset: hold reset=0 for 75 ns with hit=1 toggling clk -> outHit=0. Afterwards, reading any address (e.g. rdAddr=0x1F0) with rden=1 -> outHit=0.
- Single write/read: hit=1 at wrAddr=5, hit=0 elsewhere; later rden=1 with rdAddr=5 -> outHit=1 one cycle later. rdAddr=4 and rdAddr=6 -> outHit=0.
- Lane isolation: write 1 to addresses 8 and 10 and 0 to 9 and 11; read 8,9,10,11 -> outHit sequence 1,0,1,0.
- Hold: after a read returning 1, keep rden=0 for 20 cycles while writing zeros -> outHit stays 1.
- Full L1 stream:
  - Stimulus: counter starts at 0 after reset release; wrAddr=counter mod 512; hit=(counter%51==0); rden=(counter%40==0); rdAddr=wrAddr-501 mod 512. Run 80000 cycles.
  - Response: outHit after each rden equals a reference 512-bit array model, e.g. counter=560 reads the entry written at counter=59 (read address 59) -> outHit=0. All checks match the model, including wrap at 511 to 0.
- Collision: rden=1, rdAddr=wrAddr=0x0A3, hit=1, stored bit 0 -> outHit=0. With HIT_SRAM_WRITE_FIRST_EN defined -> outHit=1.

Source files
------------

// File: rtl/hit_sram_4b_wrapper_pkg.sv
// hit_sram_4b_wrapper_pkg: shared sizes and lane-mask helper for the 512x1 hit buffer.
package hit_sram_4b_wrapper_pkg;
    localparam int ADDR_WIDTH = 9;
    localparam int WORD_BITS = 4;
    localparam int LANE_BITS = $clog2(WORD_BITS);
    localparam int WORDS = (1 << ADDR_WIDTH) / WORD_BITS;
    localparam int WADDR_WIDTH = ADDR_WIDTH - LANE_BITS;

    function automatic logic [WORD_BITS-1:0] lane_mask(input logic [LANE_BITS-1:0] lane);
        return WORD_BITS'(1) << lane;
    endfunction
endpackage

// File: rtl/hit_sram_4b_wrapper_if.sv
// hit_sram_4b_wrapper_if: hit write / L1 read bus of the hit buffer.
interface hit_sram_4b_wrapper_if;
    import hit_sram_4b_wrapper_pkg::*;
    logic hit;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic rden;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic outHit;
    modport master(output hit, wrAddr, rden, rdAddr, input outHit);
    modport slave(input hit, wrAddr, rden, rdAddr, output outHit);
endinterface

// File: rtl/hit_sram_bank.sv
// hit_sram_bank: 128x4 storage with per-bit write mask, async active-low clear, combinational read.
module hit_sram_bank
    import hit_sram_4b_wrapper_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WADDR_WIDTH-1:0] waddr,
    input  logic [WORD_BITS-1:0]   wmask,
    input  logic [WORD_BITS-1:0]   wdata,
    input  logic [WADDR_WIDTH-1:0] raddr,
    output logic [WORD_BITS-1:0]   rdata
);
    logic [WORD_BITS-1:0] mem [WORDS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else begin
            for (int b = 0; b < WORD_BITS; b++) if (wmask[b]) mem[waddr][b] <= wdata[b];
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/hit_sram_4b_wrapper.sv
// hit_sram_4b_wrapper: circular 512x1 hit store for the L1 path, read-before-write by default.
// Define HIT_SRAM_WRITE_FIRST_EN to forward hit on a same-address read/write collision.
module hit_sram_4b_wrapper
    import hit_sram_4b_wrapper_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    hit_sram_4b_wrapper_if.slave  bus
);
    logic [WORD_BITS-1:0] rd_word;
    logic rd_bit;
    logic out_hit;

    hit_sram_bank u_bank (
        .clk   (clk),
        .reset (reset),
        .waddr (bus.wrAddr[ADDR_WIDTH-1:LANE_BITS]),
        .wmask (lane_mask(bus.wrAddr[LANE_BITS-1:0])),
        .wdata ({WORD_BITS{bus.hit}}),
        .raddr (bus.rdAddr[ADDR_WIDTH-1:LANE_BITS]),
        .rdata (rd_word)
    );

`ifdef HIT_SRAM_WRITE_FIRST_EN
    always_comb rd_bit = (bus.rdAddr == bus.wrAddr) ? bus.hit : rd_word[bus.rdAddr[LANE_BITS-1:0]];
`else
    always_comb rd_bit = rd_word[bus.rdAddr[LANE_BITS-1:0]];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_hit <= 1'b0;
        else if (bus.rden) out_hit <= rd_bit;
    end

    assign bus.outHit = out_hit;
endmodule

// File: tb/tb_hit_sram_4b_wrapper.sv
// tb_hit_sram_4b_wrapper: directed and random checks of the hit buffer against a 512-entry array model.
`timescale 1ns/100ps
module tb_hit_sram_4b_wrapper;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    bit ref_mem [512];
    logic ref_out = 1'b0;
    logic [8:0] rw, rr;

    hit_sram_4b_wrapper_if bus();
    hit_sram_4b_wrapper dut(.clk(clk), .reset(reset), .bus(bus));

    always #12.5 clk = ~clk;

    task automatic chk(input string tag, input logic exp);
        checks++;
        assert (bus.outHit === exp) else begin
            errors++;
            $error("FAIL %s outHit=%b expected=%b", tag, bus.outHit, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 512; i++) ref_mem[i] = 1'b0;
        ref_out = 1'b0;
    endtask

    task automatic step(input logic h, input logic [8:0] w, input logic r, input logic [8:0] ra);
        bus.hit = h;
        bus.wrAddr = w;
        bus.rden = r;
        bus.rdAddr = ra;
        @(posedge clk);
`ifdef HIT_SRAM_WRITE_FIRST_EN
        if (r) ref_out = (ra == w) ? h : ref_mem[ra];
`else
        if (r) ref_out = ref_mem[ra];
`endif
        ref_mem[w] = h;
        #1;
    endtask

    initial begin
        clear_model();
        bus.hit = 1'b1;
        bus.wrAddr = 9'h1F0;
        bus.rden = 1'b1;
        bus.rdAddr = 9'h1F0;
        #75;
        chk("reset_out", 1'b0);
        reset = 1'b1;
        step(1'b0, 9'd300, 1'b1, 9'h1F0);
        chk("reset_read_1f0", ref_out);
        step(1'b0, 9'd301, 1'b1, 9'h000);
        chk("reset_read_000", ref_out);
        step(1'b1, 9'd5, 1'b0, 9'd0);
        step(1'b0, 9'd4, 1'b0, 9'd0);
        step(1'b0, 9'd6, 1'b0, 9'd0);
        step(1'b0, 9'd20, 1'b1, 9'd5);
        chk("read_5", ref_out);
        step(1'b0, 9'd21, 1'b1, 9'd4);
        chk("read_4", ref_out);
        step(1'b0, 9'd22, 1'b1, 9'd6);
        chk("read_6", ref_out);
        step(1'b1, 9'd8, 1'b0, 9'd0);
        step(1'b0, 9'd9, 1'b0, 9'd0);
        step(1'b1, 9'd10, 1'b0, 9'd0);
        step(1'b0, 9'd11, 1'b0, 9'd0);
        for (int i = 8; i < 12; i++) begin
            step(1'b0, 9'(100 + i), 1'b1, 9'(i));
            chk("lane_read", ref_out);
        end
        step(1'b1, 9'd9, 1'b1, 9'd8);
        chk("lane_same_word", ref_out);
        step(1'b0, 9'd120, 1'b1, 9'd9);
        chk("lane_after_write", ref_out);
        step(1'b0, 9'd121, 1'b1, 9'd10);
        chk("hold_setup", ref_out);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 9'(200 + i), 1'b0, 9'd10);
            chk("hold", ref_out);
        end
        step(1'b0, 9'h0A3, 1'b0, 9'd0);
        step(1'b1, 9'h0A3, 1'b1, 9'h0A3);
        chk("collision", ref_out);
        step(1'b0, 9'd250, 1'b1, 9'h0A3);
        chk("collision_after", ref_out);
        for (int i = 0; i < 400; i++) begin
            rw = 9'($urandom_range(0, 31));
            rr = ($urandom_range(0, 3) == 0) ? rw : 9'($urandom_range(0, 31));
            step(1'($urandom), rw, 1'($urandom), rr);
            chk("random", ref_out);
        end
        step(1'b1, 9'd5, 1'b1, 9'd10);
        reset = 1'b0;
        #1;
        clear_model();
        chk("midreset_out", 1'b0);
        bus.hit = 1'b1;
        bus.rden = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #5;
        reset = 1'b1;
        step(1'b0, 9'd40, 1'b1, 9'd5);
        chk("midreset_read5", ref_out);
        step(1'b0, 9'd41, 1'b1, 9'd8);
        chk("midreset_read8", ref_out);
        reset = 1'b0;
        #1;
        clear_model();
        #20;
        reset = 1'b1;
        for (int c = 0; c < 80000; c++) begin
            step(1'(c % 51 == 0), c[8:0], 1'(c % 40 == 0), c[8:0] - 9'd501);
            if (c % 40 == 0) chk("l1_stream", ref_out);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
